bsg_fsb_node_level_shift_fsb_domain_ctrl: RTL and testbench

FSB-domain counterpart of the node-domain level-shift wrapper. It sits on the always-on FSB side of a power-gated node and drives the isolation enable for the node's level shifters. It sequences power-up and power-down of the crossing, buffers node→FSB traffic in a small FIFO, and holds FSB→node traffic in a one-entry register. No flit is lost or duplicated across enable transitions.

---
 rtl/bsg_fsb_node_level_shift_fsb_domain_ctrl.sv | 158 +++++++++++++++
 tb/tb_bsg_fsb_node_level_shift_fsb_domain_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_fsb_node_level_shift_fsb_domain_ctrl.sv
// FSB-side power sequencer for a gated node: drives level-shifter enable, buffers node->FSB flits,
// and holds one FSB->node flit. Optional DRAIN watchdog: BSG_FSB_NODE_LS_DRAIN_TIMEOUT_EN.
module bsg_fsb_node_level_shift_fsb_domain_ctrl #(
  parameter int width_p       = 5,
  parameter int els_p         = 2,
  parameter int wake_cycles_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               power_on_i,
  output logic               en_ls_o,
  output logic               node_up_o,
  output logic               drop_o,
  input  logic               ls_v_i,
  input  logic [width_p-1:0] ls_data_i,
  output logic               ls_yumi_o,
  output logic               ls_v_o,
  output logic [width_p-1:0] ls_data_o,
  input  logic               ls_ready_i,
  output logic               fsb_v_o,
  output logic [width_p-1:0] fsb_data_o,
  input  logic               fsb_yumi_i,
  input  logic               fsb_v_i,
  input  logic [width_p-1:0] fsb_data_i,
  output logic               fsb_ready_o
);
  localparam int PTR_W = $clog2(els_p);
  localparam int WC_W  = $clog2(wake_cycles_p + 1);
  localparam logic [WC_W-1:0] WAKE_LAST = WC_W'(wake_cycles_p - 1);

  typedef enum logic [1:0] {S_OFF, S_WAKE, S_ON, S_DRAIN} state_e;

  state_e             r_state;
  logic               r_en_ls, r_node_up;
  logic [WC_W-1:0]    r_wake_cnt;
  logic               r_tx_v;
  logic [width_p-1:0] r_tx_data;
  logic [width_p-1:0] r_mem [els_p];
  logic [PTR_W:0]     r_wptr, r_rptr;

  logic w_traffic, w_empty, w_full, w_tx_deq, w_tx_enq, w_fifo_deq, w_timeout;

  // Node-side handshakes are only honoured once the shifters have settled.
  assign w_traffic  = (r_state == S_ON) || (r_state == S_DRAIN);
  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                      (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);

  assign ls_yumi_o  = ls_v_i & ~w_full & w_traffic;
  assign fsb_v_o    = ~w_empty;
  assign fsb_data_o = w_empty ? '0 : r_mem[r_rptr[PTR_W-1:0]];
  assign w_fifo_deq = fsb_yumi_i & fsb_v_o;

  assign ls_v_o      = r_tx_v & w_traffic;
  assign ls_data_o   = ls_v_o ? r_tx_data : '0;
  assign w_tx_deq    = ls_v_o & ls_ready_i;
  assign fsb_ready_o = (r_state == S_ON) & (~r_tx_v | w_tx_deq);
  assign w_tx_enq    = fsb_v_i & fsb_ready_o;

  assign en_ls_o   = r_en_ls;
  assign node_up_o = r_node_up;

`ifdef BSG_FSB_NODE_LS_DRAIN_TIMEOUT_EN
  logic [7:0] r_drain_cnt;
  logic       r_drop;

  // Give up on the held flit after 255 DRAIN cycles.
  assign w_timeout = (r_state == S_DRAIN) && !power_on_i && r_tx_v && !w_tx_deq &&
                     (r_drain_cnt == 8'd254);
  assign drop_o    = r_drop;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_drain_cnt <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 8'd1 : 8'd0;
      r_drop      <= w_timeout;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign drop_o    = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= S_OFF;
      r_en_ls    <= 1'b0;
      r_node_up  <= 1'b0;
      r_wake_cnt <= '0;
    end else begin
      case (r_state)
        S_OFF: if (power_on_i) begin
          r_state    <= S_WAKE;
          r_en_ls    <= 1'b1;
          r_wake_cnt <= '0;
        end
        S_WAKE: begin
          if (!power_on_i) begin
            r_state <= S_OFF;
            r_en_ls <= 1'b0;
          end else if (r_wake_cnt == WAKE_LAST) begin
            r_state   <= S_ON;
            r_node_up <= 1'b1;
          end else begin
            r_wake_cnt <= r_wake_cnt + 1'b1;
          end
        end
        S_ON: if (!power_on_i) begin
          r_state   <= S_DRAIN;
          r_node_up <= 1'b0;
        end
        S_DRAIN: begin
          if (power_on_i) begin
            r_state   <= S_ON;
            r_node_up <= 1'b1;
          end else if (!r_tx_v || w_tx_deq || w_timeout) begin
            r_state <= S_OFF;
            r_en_ls <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_OFF;
          r_en_ls   <= 1'b0;
          r_node_up <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_tx_v    <= 1'b0;
      r_tx_data <= '0;
    end else if (w_tx_enq) begin
      r_tx_v    <= 1'b1;
      r_tx_data <= fsb_data_i;
    end else if (w_tx_deq || w_timeout) begin
      r_tx_v    <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (ls_yumi_o)  r_wptr <= r_wptr + 1'b1;
      if (w_fifo_deq) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (ls_yumi_o) r_mem[r_wptr[PTR_W-1:0]] <= ls_data_i;
  end
endmodule

// File: tb/tb_bsg_fsb_node_level_shift_fsb_domain_ctrl.sv
// Directed bench for the FSB-domain level-shift controller (width 5, 2-deep FIFO, 4 wake cycles).
module tb_bsg_fsb_node_level_shift_fsb_domain_ctrl;
  logic       clk_i = 1'b0, reset_i = 1'b1, power_on_i = 1'b0;
  logic       en_ls_o, node_up_o, drop_o;
  logic       ls_v_i = 1'b0, ls_yumi_o, ls_v_o, ls_ready_i = 1'b0;
  logic [4:0] ls_data_i = '0, ls_data_o, fsb_data_o, fsb_data_i = '0;
  logic       fsb_v_o, fsb_yumi_i = 1'b0, fsb_v_i = 1'b0, fsb_ready_o;
  int ncmp = 0, nerr = 0;

  bsg_fsb_node_level_shift_fsb_domain_ctrl #(.width_p(5), .els_p(2), .wake_cycles_p(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .power_on_i(power_on_i),
    .en_ls_o(en_ls_o), .node_up_o(node_up_o), .drop_o(drop_o),
    .ls_v_i(ls_v_i), .ls_data_i(ls_data_i), .ls_yumi_o(ls_yumi_o),
    .ls_v_o(ls_v_o), .ls_data_o(ls_data_o), .ls_ready_i(ls_ready_i),
    .fsb_v_o(fsb_v_o), .fsb_data_o(fsb_data_o), .fsb_yumi_i(fsb_yumi_i),
    .fsb_v_i(fsb_v_i), .fsb_data_i(fsb_data_i), .fsb_ready_o(fsb_ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    logic [31:0] got;
    #3;
    got = {en_ls_o, node_up_o, drop_o, ls_yumi_o, ls_v_o, ls_data_o, fsb_v_o, fsb_data_o, fsb_ready_o};
    ncmp++; if (got !== 32'd0) begin nerr++; $display("FAIL reset_outputs got %h want 0", got); end
    tick(); tick();
    reset_i = 1'b0;
    sample();
    ncmp++; if (en_ls_o !== 1'b0) begin nerr++; $display("FAIL reset_en_ls got %b want 0", en_ls_o); end
    tick();
  endtask

  task automatic test_power_up();
    power_on_i = 1'b1; ls_v_i = 1'b1; ls_data_i = 5'h0A;
    sample();
    ncmp++; if ({en_ls_o, ls_yumi_o} !== 2'b00) begin nerr++; $display("FAIL pu_off got en/yumi %b want 00", {en_ls_o, ls_yumi_o}); end
    tick();
    for (int i = 1; i <= 4; i++) begin
      sample();
      ncmp++; if ({en_ls_o, node_up_o, ls_yumi_o} !== 3'b100) begin
        nerr++; $display("FAIL pu_wake%0d got en/up/yumi %b want 100", i, {en_ls_o, node_up_o, ls_yumi_o}); end
      tick();
    end
    sample();
    ncmp++; if ({node_up_o, ls_yumi_o} !== 2'b11) begin nerr++; $display("FAIL pu_on got up/yumi %b want 11", {node_up_o, ls_yumi_o}); end
    ls_v_i = 1'b0;
    tick();
  endtask

  task automatic test_streaming();
    ls_ready_i = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      fsb_v_i = (k < 8); fsb_data_i = 5'(k + 1);
      sample();
      if (k < 8) begin
        ncmp++; if (fsb_ready_o !== 1'b1) begin nerr++; $display("FAIL stream_ready%0d got %b want 1", k, fsb_ready_o); end
      end
      if (k > 0) begin
        ncmp++; if ({ls_v_o, ls_data_o} !== {1'b1, 5'(k)}) begin
          nerr++; $display("FAIL stream_out%0d got v=%b d=%h want v=1 d=%h", k, ls_v_o, ls_data_o, 5'(k)); end
      end else begin
        ncmp++; if (ls_v_o !== 1'b0) begin nerr++; $display("FAIL stream_idle got %b want 0", ls_v_o); end
      end
      tick();
    end
    fsb_v_i = 1'b0;
    sample();
    ncmp++; if ({ls_v_o, ls_data_o} !== 6'd0) begin nerr++; $display("FAIL stream_end got v=%b d=%h want 0", ls_v_o, ls_data_o); end
    tick();
  endtask

  task automatic test_backpressure();
    fsb_yumi_i = 1'b0; ls_v_i = 1'b1; ls_data_i = 5'h11;
    sample();
    ncmp++; if ({ls_yumi_o, fsb_v_o} !== 2'b10) begin nerr++; $display("FAIL bp_push1 got yumi/fv %b want 10", {ls_yumi_o, fsb_v_o}); end
    tick(); ls_data_i = 5'h12;
    sample();
    ncmp++; if ({ls_yumi_o, fsb_v_o, fsb_data_o} !== {2'b11, 5'h11}) begin
      nerr++; $display("FAIL bp_push2 got yumi=%b fv=%b d=%h want 1 1 11", ls_yumi_o, fsb_v_o, fsb_data_o); end
    tick(); ls_data_i = 5'h13;
    for (int i = 0; i < 2; i++) begin
      sample();
      ncmp++; if (ls_yumi_o !== 1'b0) begin nerr++; $display("FAIL bp_full%0d got yumi %b want 0", i, ls_yumi_o); end
      tick();
    end
    fsb_yumi_i = 1'b1;
    sample();
    ncmp++; if ({ls_yumi_o, fsb_v_o, fsb_data_o} !== {2'b01, 5'h11}) begin
      nerr++; $display("FAIL bp_pop1 got yumi=%b fv=%b d=%h want 0 1 11", ls_yumi_o, fsb_v_o, fsb_data_o); end
    tick();
    sample();
    ncmp++; if ({ls_yumi_o, fsb_v_o, fsb_data_o} !== {2'b11, 5'h12}) begin
      nerr++; $display("FAIL bp_pop2 got yumi=%b fv=%b d=%h want 1 1 12", ls_yumi_o, fsb_v_o, fsb_data_o); end
    tick(); ls_v_i = 1'b0;
    sample();
    ncmp++; if ({fsb_v_o, fsb_data_o} !== {1'b1, 5'h13}) begin
      nerr++; $display("FAIL bp_pop3 got fv=%b d=%h want 1 13", fsb_v_o, fsb_data_o); end
    tick();
    sample();
    ncmp++; if ({fsb_v_o, fsb_data_o} !== 6'd0) begin nerr++; $display("FAIL bp_empty got fv=%b d=%h want 0", fsb_v_o, fsb_data_o); end
    fsb_yumi_i = 1'b0;
    tick();
  endtask

  // Loads 0x1F into tx with the node stalled, then requests power-down; ends in the first DRAIN cycle.
  task automatic load_and_drop_power();
    ls_ready_i = 1'b0; fsb_v_i = 1'b1; fsb_data_i = 5'h1F;
    sample();
    ncmp++; if (fsb_ready_o !== 1'b1) begin nerr++; $display("FAIL load_ready got %b want 1", fsb_ready_o); end
    tick(); fsb_v_i = 1'b0; power_on_i = 1'b0;
    sample();
    ncmp++; if ({ls_v_o, ls_data_o, fsb_ready_o} !== {1'b1, 5'h1F, 1'b0}) begin
      nerr++; $display("FAIL load_held got v=%b d=%h rdy=%b want 1 1f 0", ls_v_o, ls_data_o, fsb_ready_o); end
    tick();
  endtask

  task automatic test_drain();
    int bad = 0;
    load_and_drop_power();
    for (int i = 0; i < 20; i++) begin
      fsb_v_i = 1'b1; fsb_data_i = 5'h05;
      sample();
      ncmp++; if ({fsb_ready_o, ls_v_o, ls_data_o, en_ls_o, node_up_o, drop_o} !== {2'b01, 5'h1F, 3'b100}) begin
        nerr++; bad++;
        if (bad < 4) $display("FAIL drain_hold%0d got rdy=%b v=%b d=%h en=%b up=%b drop=%b want 0 1 1f 1 0 0",
                              i, fsb_ready_o, ls_v_o, ls_data_o, en_ls_o, node_up_o, drop_o);
      end
      tick();
    end
    fsb_v_i = 1'b0; ls_ready_i = 1'b1;
    sample();
    ncmp++; if ({ls_v_o, ls_data_o, en_ls_o} !== {1'b1, 5'h1F, 1'b1}) begin
      nerr++; $display("FAIL drain_deliver got v=%b d=%h en=%b want 1 1f 1", ls_v_o, ls_data_o, en_ls_o); end
    tick();
    sample();
    ncmp++; if ({en_ls_o, ls_v_o, node_up_o, drop_o} !== 4'b0000) begin
      nerr++; $display("FAIL drain_off got en/v/up/drop %b want 0000", {en_ls_o, ls_v_o, node_up_o, drop_o}); end
    tick();
  endtask

  task automatic test_abort();
    power_on_i = 1'b1;
    sample(); tick();
    sample();
    ncmp++; if (en_ls_o !== 1'b1) begin nerr++; $display("FAIL abort_wake1 got en %b want 1", en_ls_o); end
    tick(); power_on_i = 1'b0;
    sample(); tick();
    for (int i = 0; i < 6; i++) begin
      sample();
      ncmp++; if ({en_ls_o, node_up_o} !== 2'b00) begin nerr++; $display("FAIL abort_off%0d got en/up %b want 00", i, {en_ls_o, node_up_o}); end
      tick();
    end
  endtask

  task automatic power_up_to_on(input string tag);
    power_on_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    sample();
    ncmp++; if (node_up_o !== 1'b1) begin nerr++; $display("FAIL %s_up got %b want 1", tag, node_up_o); end
    tick();
  endtask

`ifdef BSG_FSB_NODE_LS_DRAIN_TIMEOUT_EN
  task automatic test_timeout();
    int d = 0;
    power_up_to_on("to");
    load_and_drop_power();
    sample();
    while (en_ls_o && d < 300) begin
      if (drop_o !== 1'b0) begin ncmp++; nerr++; $display("FAIL to_early_drop at %0d", d); end
      tick(); sample(); d++;
    end
    ncmp++; if (d !== 255) begin nerr++; $display("FAIL to_cycles got %0d want 255", d); end
    ncmp++; if ({drop_o, en_ls_o, ls_v_o} !== 3'b100) begin
      nerr++; $display("FAIL to_drop got drop/en/v %b want 100", {drop_o, en_ls_o, ls_v_o}); end
    tick(); sample();
    ncmp++; if (drop_o !== 1'b0) begin nerr++; $display("FAIL to_pulse got %b want 0", drop_o); end
    tick();
  endtask
`endif

  task automatic test_async_reset();
    logic [31:0] got;
    power_up_to_on("ar");
    ls_ready_i = 1'b0; fsb_v_i = 1'b1; fsb_data_i = 5'h0C; ls_v_i = 1'b1; ls_data_i = 5'h07;
    tick(); fsb_v_i = 1'b0; ls_v_i = 1'b0;
    sample();
    ncmp++; if ({ls_v_o, fsb_v_o, fsb_data_o} !== {2'b11, 5'h07}) begin
      nerr++; $display("FAIL ar_loaded got v=%b fv=%b d=%h want 1 1 07", ls_v_o, fsb_v_o, fsb_data_o); end
    #1 reset_i = 1'b1; power_on_i = 1'b0;
    #1 got = {en_ls_o, node_up_o, drop_o, ls_yumi_o, ls_v_o, ls_data_o, fsb_v_o, fsb_data_o, fsb_ready_o};
    ncmp++; if (got !== 32'd0) begin nerr++; $display("FAIL ar_outputs got %h want 0", got); end
    tick(); reset_i = 1'b0;
    sample();
    ncmp++; if ({fsb_v_o, ls_v_o, en_ls_o, drop_o} !== 4'b0000) begin
      nerr++; $display("FAIL ar_after got fv/v/en/drop %b want 0000", {fsb_v_o, ls_v_o, en_ls_o, drop_o}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_streaming();
    test_backpressure();
    test_drain();
    test_abort();
`ifdef BSG_FSB_NODE_LS_DRAIN_TIMEOUT_EN
    test_timeout();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
